tug_field: RTL and testbench



---
 rtl/tug_pkg.sv | 15 +
 rtl/edge_detect.sv | 22 ++
 rtl/tug_field.sv | 141 ++++++++++++++
 tb/tb_tug_field.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield controller.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide one-hot centre pattern; callers cast it down to their field width.
    function automatic logic [63:0] center_onehot(input int n);
        return 64'd1 << (n / 2);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one already-synchronised button level.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic evt
);

    logic level_q;

    // Reset loads the live level so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= level;
        end else begin
            level_q <= level;
        end
    end

    assign evt = level & ~level_q;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: one lit position, per-player scoring, timed re-centring.
module tug_field
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l_press,
    input  logic                  r_press,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  l_win,
    output logic                  r_win,
    output logic [SCORE_W-1:0]    l_score,
    output logic [SCORE_W-1:0]    r_score,
    output logic                  game_over,
    output logic                  match_over
);

    localparam logic [NUM_LIGHTS-1:0] CENTER = NUM_LIGHTS'(center_onehot(NUM_LIGHTS));
    localparam int                    HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;

    logic [1:0] level;
    logic [1:0] evt;
    logic       l_evt;
    logic       r_evt;

    assign level = {l_press, r_press};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        edge_detect u_edge (
            .clk   (clk),
            .reset (reset),
            .level (level[gi]),
            .evt   (evt[gi])
        );
    end

    assign l_evt = evt[1];
    assign r_evt = evt[0];

    state_t                state_reg, state_next;
    logic [NUM_LIGHTS-1:0] lights_reg, lights_next;
    logic [SCORE_W-1:0]    l_score_reg, l_score_next;
    logic [SCORE_W-1:0]    r_score_reg, r_score_next;
    logic [HOLD_W-1:0]     hold_reg, hold_next;
    logic                  l_win_reg, l_win_next;
    logic                  r_win_reg, r_win_next;
    logic                  match_over_reg, match_over_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= PLAY;
            lights_reg     <= CENTER;
            l_score_reg    <= '0;
            r_score_reg    <= '0;
            hold_reg       <= '0;
            l_win_reg      <= 1'b0;
            r_win_reg      <= 1'b0;
            match_over_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lights_reg     <= lights_next;
            l_score_reg    <= l_score_next;
            r_score_reg    <= r_score_next;
            hold_reg       <= hold_next;
            l_win_reg      <= l_win_next;
            r_win_reg      <= r_win_next;
            match_over_reg <= match_over_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lights_next     = lights_reg;
        l_score_next    = l_score_reg;
        r_score_next    = r_score_reg;
        hold_next       = hold_reg;
        l_win_next      = 1'b0;
        r_win_next      = 1'b0;
        match_over_next = match_over_reg;
        case (state_reg)
            PLAY: begin
                // Simultaneous events cancel, so only a lone event acts.
                if (l_evt && !r_evt) begin
                    if (lights_reg[NUM_LIGHTS-1]) begin
                        l_score_next = l_score_reg + 1'b1;
                        l_win_next   = 1'b1;
                        lights_next  = '0;
                        hold_next    = HOLD_LOAD;
                        state_next   = HOLD;
                    end else begin
                        lights_next = lights_reg << 1;
                    end
                end else if (r_evt && !l_evt) begin
                    if (lights_reg[0]) begin
                        r_score_next = r_score_reg + 1'b1;
                        r_win_next   = 1'b1;
                        lights_next  = '0;
                        hold_next    = HOLD_LOAD;
                        state_next   = HOLD;
                    end else begin
                        lights_next = lights_reg >> 1;
                    end
                end
            end
            HOLD: begin
                if (hold_reg == '0) begin
                    if (l_score_reg == SCORE_MAX || r_score_reg == SCORE_MAX) begin
                        state_next      = DONE;
                        match_over_next = 1'b1;
                    end else begin
                        state_next  = PLAY;
                        lights_next = CENTER;
                    end
                end else begin
                    hold_next = hold_reg - 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_next  = PLAY;
                lights_next = CENTER;
            end
        endcase
    end

    assign lights     = lights_reg;
    assign l_win      = l_win_reg;
    assign r_win      = r_win_reg;
    assign l_score    = l_score_reg;
    assign r_score    = r_score_reg;
    assign game_over  = (state_reg != PLAY);
    assign match_over = match_over_reg;

endmodule

// File: tb/tb_tug_field.sv
// Randomised and directed checks of tug_field against a position/score model.
module tb_tug_field;

    localparam int N    = 5;
    localparam int SW   = 2;
    localparam int HOLD = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          l_press = 1'b0;
    logic          r_press = 1'b0;
    logic [N-1:0]  lights;
    logic          l_win;
    logic          r_win;
    logic [SW-1:0] l_score;
    logic [SW-1:0] r_score;
    logic          game_over;
    logic          match_over;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = playing, 1 = dark after a point, 2 = match finished.
    int m_pos, m_ls, m_rs, m_mode, m_hold_left;
    int m_lprev, m_rprev, m_lwin, m_rwin;

    tug_field #(
        .NUM_LIGHTS  (N),
        .SCORE_W     (SW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .l_press    (l_press),
        .r_press    (r_press),
        .lights     (lights),
        .l_win      (l_win),
        .r_win      (r_win),
        .l_score    (l_score),
        .r_score    (r_score),
        .game_over  (game_over),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int rst, input int l, input int r);
        int le, re;
        if (rst != 0) begin
            m_pos = N / 2; m_ls = 0; m_rs = 0; m_mode = 0; m_hold_left = 0;
            m_lwin = 0; m_rwin = 0; m_lprev = l; m_rprev = r;
            return;
        end
        le = (l != 0 && m_lprev == 0) ? 1 : 0;
        re = (r != 0 && m_rprev == 0) ? 1 : 0;
        m_lprev = l; m_rprev = r;
        m_lwin = 0; m_rwin = 0;
        if (m_mode == 0) begin
            if (le == 1 && re == 0) begin
                if (m_pos == N - 1) begin
                    m_ls++; m_lwin = 1; m_mode = 1; m_hold_left = HOLD;
                end else m_pos++;
            end else if (re == 1 && le == 0) begin
                if (m_pos == 0) begin
                    m_rs++; m_rwin = 1; m_mode = 1; m_hold_left = HOLD;
                end else m_pos--;
            end
        end else if (m_mode == 1) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                if (m_ls == SMAX || m_rs == SMAX) m_mode = 2;
                else begin m_mode = 0; m_pos = N / 2; end
            end
        end
    endtask

    task automatic cycle(input int rst, input int l, input int r);
        logic [N-1:0] exp_lights;
        reset   = (rst != 0);
        l_press = (l != 0);
        r_press = (r != 0);
        @(posedge clk);
        model_step(rst, l, r);
        #1;
        exp_lights = (m_mode == 0) ? N'(1 << m_pos) : '0;
        chk("lights", 32'(lights), 32'(exp_lights));
        chk("l_win", 32'(l_win), 32'(m_lwin));
        chk("r_win", 32'(r_win), 32'(m_rwin));
        chk("l_score", 32'(l_score), 32'(m_ls));
        chk("r_score", 32'(r_score), 32'(m_rs));
        chk("game_over", 32'(game_over), 32'(m_mode != 0));
        chk("match_over", 32'(match_over), 32'(m_mode == 2));
        // Field shape invariant: one-hot while playing, dark otherwise.
        chk("lights_shape", 32'(game_over ? (lights == '0) : $onehot(lights)), 32'd1);
        $display("cyc rst=%0d l=%0d r=%0d lights=%b lw=%0d rw=%0d ls=%0d rs=%0d go=%0d mo=%0d",
                 rst, l, r, lights, l_win, r_win, l_score, r_score, game_over, match_over);
    endtask

    initial begin
        int pl, pr, steps;
        // Reset with left held, then release: no move.
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("rst_lights", 32'(lights), 32'h04);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("held_thru_rst", 32'(lights), 32'h04);

        // Two left taps, then a scoring tap and the hold window.
        cycle(0, 1, 0); chk("tap1", 32'(lights), 32'h08);
        cycle(0, 0, 0);
        cycle(0, 1, 0); chk("tap2", 32'(lights), 32'h10);
        cycle(0, 0, 0);
        cycle(0, 1, 0); chk("score_pulse", 32'(l_win), 32'd1);
        chk("score_l", 32'(l_score), 32'd1);
        cycle(0, 0, 0); chk("pulse_1cyc", 32'(l_win), 32'd0);
        cycle(0, 0, 0); chk("hold_dark", 32'(lights), 32'h00);
        cycle(0, 0, 0); chk("recentre", 32'(lights), 32'h04);
        chk("recentre_go", 32'(game_over), 32'd0);

        // Simultaneous rise cancels; held button moves once.
        cycle(0, 1, 1); chk("cancel", 32'(lights), 32'h04);
        cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        chk("held_once", 32'(lights), 32'h08);
        cycle(0, 0, 0);

        // Right taps until match ends; left mashed throughout holds.
        steps = 0;
        while (m_mode != 2 && steps < 200) begin
            cycle(0, m_mode == 1 ? 1 : 0, 1);
            cycle(0, 0, 0);
            steps += 2;
        end
        chk("match_reached", 32'(steps < 200), 32'd1);
        chk("final_r", 32'(r_score), 32'(SMAX));
        chk("final_mo", 32'(match_over), 32'd1);
        for (int i = 0; i < 6; i++) cycle(0, i % 2, (i + 1) % 2);
        chk("done_dark", 32'(lights), 32'h00);
        cycle(1, 0, 0);
        chk("reset_centre", 32'(lights), 32'h04);
        chk("reset_scores", 32'({l_score, r_score}), 32'd0);

        // Randomised play with shifting press densities and rare resets.
        pl = 30; pr = 30;
        for (int k = 0; k < 3000; k++) begin
            if (k % 60 == 0) begin
                pl = $urandom_range(5, 70);
                pr = $urandom_range(5, 70);
            end
            cycle(($urandom_range(0, 399) == 0) ? 1 : 0,
                  ($urandom_range(0, 99) < pl) ? 1 : 0,
                  ($urandom_range(0, 99) < pr) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
